// File: rtl/ip_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_fifo_pkg
// Description : Shared types and default constants for the FIFO loopback
//               exercise block (writer/reader state encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package ip_fifo_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 256;
    localparam int WAIT_CYC_DEF = 2;

    // Writer FSM: wait for an empty FIFO, settle, then fill it completely.
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WAIT  = 2'd1,
        W_WRITE = 2'd2
    } wr_state_t;

    // Reader FSM: wait for a full FIFO, settle, then drain it completely.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_READ = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data (1-cycle read
//               latency), word count and full/empty flags derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import ip_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Requests against a full/empty FIFO are dropped here, not upstream.
    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Storage array; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Registered read port; rd_data holds the last word actually read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign full     = w_full;
    assign empty    = w_empty;
    assign cnt      = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ip_fifo_loopback.sv
`default_nettype none
// ============================================================================
// Module      : ip_fifo_loopback
// Description : Self-running FIFO exercise: a writer fills the FIFO with an
//               incrementing pattern when empty, a reader drains and checks
//               it when full. Mismatches set a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_fifo_loopback
    import ip_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF   // must be >= 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  fifo_cnt,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    err,
    output logic [15:0]             round_cnt
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(WAIT_CYC + 1);

    wr_state_t         r_wr_state;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [WAIT_W-1:0] r_wr_wait;

    rd_state_t         r_rd_state;
    logic [CNT_W-1:0]  r_rd_cyc;
    logic [WAIT_W-1:0] r_rd_wait;

    logic [CNT_W-1:0]  r_exp;
    logic              r_err;
    logic [15:0]       r_round_cnt;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_start;

    assign w_wr_en    = (r_wr_state == W_WRITE) && !w_full;
    assign w_wr_data  = DATA_W'(r_wr_cnt);
    assign w_rd_en    = (r_rd_state == R_READ) && !w_empty;
    assign w_rd_start = (r_rd_state == R_WAIT) && (r_rd_wait == WAIT_W'(WAIT_CYC - 1));

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .wr_en    (w_wr_en),
        .wr_data  (w_wr_data),
        .rd_en    (w_rd_en),
        .rd_data  (w_rd_data),
        .rd_valid (w_rd_valid),
        .full     (w_full),
        .empty    (w_empty),
        .cnt      (fifo_cnt)
    );

    // Writer: on empty, settle WAIT_CYC cycles then write 0..DEPTH-1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= '0;
            r_wr_wait  <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    r_wr_cnt  <= '0;
                    r_wr_wait <= '0;
                    if (w_empty) begin
                        r_wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (r_wr_wait == WAIT_W'(WAIT_CYC - 1)) begin
                        r_wr_state <= W_WRITE;
                    end else begin
                        r_wr_wait <= r_wr_wait + WAIT_W'(1);
                    end
                end
                W_WRITE: begin
                    if (w_wr_en) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        if (r_wr_cnt == CNT_W'(DEPTH - 1)) begin
                            r_wr_state <= W_IDLE;
                        end
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Reader: on full, settle WAIT_CYC cycles then request DEPTH reads.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cyc   <= '0;
            r_rd_wait  <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    r_rd_cyc  <= '0;
                    r_rd_wait <= '0;
                    if (w_full) begin
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (w_rd_start) begin
                        r_rd_state <= R_READ;
                    end else begin
                        r_rd_wait <= r_rd_wait + WAIT_W'(1);
                    end
                end
                R_READ: begin
                    r_rd_cyc <= r_rd_cyc + CNT_W'(1);
                    if (r_rd_cyc == CNT_W'(DEPTH - 1)) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Checker: compare each returned word with the running expectation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_exp       <= '0;
            r_err       <= 1'b0;
            r_round_cnt <= '0;
        end else if (w_rd_start) begin
            r_exp <= '0;
        end else if (w_rd_valid) begin
            if (w_rd_data != DATA_W'(r_exp)) begin
                r_err <= 1'b1;
            end
            if (r_exp == CNT_W'(DEPTH - 1)) begin
                r_round_cnt <= r_round_cnt + 16'd1;
            end
            r_exp <= r_exp + CNT_W'(1);
        end
    end

    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign rd_data    = w_rd_data;
    assign rd_valid   = w_rd_valid;
    assign err        = r_err;
    assign round_cnt  = r_round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ip_fifo_loopback.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_fifo_loopback
// Description : Directed self-checking bench for ip_fifo_loopback plus a
//               standalone sync_fifo instance for boundary cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_fifo_loopback;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_cnt;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        err;
    logic [15:0] round_cnt;

    logic        f_rst;
    logic        f_wr;
    logic [7:0]  f_wd;
    logic        f_rd;
    logic [7:0]  f_rdata;
    logic        f_rvalid;
    logic        f_full;
    logic        f_empty;
    logic [8:0]  f_cnt;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    ip_fifo_loopback #(
        .DATA_W   (8),
        .DEPTH    (256),
        .WAIT_CYC (2)
    ) u_dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_cnt   (fifo_cnt),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err),
        .round_cnt  (round_cnt)
    );

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (256)
    ) u_fifo_t (
        .clk      (clk),
        .rst      (f_rst),
        .wr_en    (f_wr),
        .wr_data  (f_wd),
        .rd_en    (f_rd),
        .rd_data  (f_rdata),
        .rd_valid (f_rvalid),
        .full     (f_full),
        .empty    (f_empty),
        .cnt      (f_cnt)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges;
        int cyc;

        sys_rst = 1'b1;
        f_rst   = 1'b1;
        f_wr    = 1'b0;
        f_rd    = 1'b0;
        f_wd    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_value("rst_empty", 32'(fifo_empty), 32'd1);
        check_value("rst_full", 32'(fifo_full), 32'd0);
        check_value("rst_cnt", 32'(fifo_cnt), 32'd0);
        check_value("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_value("rst_rd_data", 32'(rd_data), 32'd0);
        check_value("rst_err", 32'(err), 32'd0);
        check_value("rst_round", 32'(round_cnt), 32'd0);

        // Release reset: first write request after edge 3
        sys_rst = 1'b0;
        edges = 0;
        while (!u_dut.w_wr_en && edges < 20) begin
            tick();
            edges++;
        end
        check_value("wr_start_edges", 32'(edges), 32'd3);

        // 256 consecutive writes of 0..255
        for (int i = 0; i < 256; i++) begin
            check_value("wr_seq", 32'({u_dut.w_wr_en, u_dut.w_wr_data}), 32'({1'b1, 8'(i)}));
            tick();
        end
        check_value("fill_full", 32'(fifo_full), 32'd1);
        check_value("fill_cnt", 32'(fifo_cnt), 32'd256);
        check_value("fill_wr_en_low", 32'(u_dut.w_wr_en), 32'd0);

        // Reader: full seen, 2 settle cycles, 1 cycle read latency
        edges = 0;
        while (!rd_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_value("rd_start_edges", 32'(edges), 32'd4);

        for (int i = 0; i < 256; i++) begin
            check_value("rd_seq", 32'({rd_valid, rd_data}), 32'({1'b1, 8'(i)}));
            tick();
        end
        check_value("drain_empty", 32'(fifo_empty), 32'd1);
        check_value("drain_round", 32'(round_cnt), 32'd1);
        check_value("drain_err", 32'(err), 32'd0);
        check_value("drain_rd_valid", 32'(rd_valid), 32'd0);

        // Free-run to three completed rounds
        cyc = 0;
        while (round_cnt != 16'd3 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check_value("round3", 32'(round_cnt), 32'd3);
        check_value("round3_err", 32'(err), 32'd0);

        // Corrupt word 17 on its way to the checker
        cyc = 0;
        while (!(rd_valid && rd_data == 8'd17) && cyc < 3000) begin
            tick();
            cyc++;
        end
        check_value("hit_word17", 32'({rd_valid, rd_data}), 32'({1'b1, 8'd17}));
        check_value("pre_corrupt_err", 32'(err), 32'd0);
        force u_dut.w_rd_data = 8'hFF;
        @(posedge clk);
        #1;
        release u_dut.w_rd_data;
        check_value("corrupt_err", 32'(err), 32'd1);
        @(negedge clk);

        cyc = 0;
        while (round_cnt != 16'd5 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check_value("round5", 32'(round_cnt), 32'd5);
        check_value("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a write burst
        cyc = 0;
        while (!(fifo_cnt == 9'd100 && u_dut.w_wr_en) && cyc < 3000) begin
            tick();
            cyc++;
        end
        check_value("midwr_cnt", 32'(fifo_cnt), 32'd100);
        sys_rst = 1'b1;
        tick();
        check_value("midrst_cnt", 32'(fifo_cnt), 32'd0);
        check_value("midrst_empty", 32'(fifo_empty), 32'd1);
        check_value("midrst_err", 32'(err), 32'd0);
        check_value("midrst_round", 32'(round_cnt), 32'd0);
        check_value("midrst_wr_en", 32'(u_dut.w_wr_en), 32'd0);
        sys_rst = 1'b0;
        edges = 0;
        while (!u_dut.w_wr_en && edges < 20) begin
            tick();
            edges++;
        end
        check_value("restart_edges", 32'(edges), 32'd3);
        check_value("restart_data", 32'(u_dut.w_wr_data), 32'd0);

        // Standalone FIFO: simultaneous read/write at count 5
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f_wr = 1'b1;
            f_wd = 8'(10 + i);
            tick();
        end
        f_wr = 1'b0;
        check_value("f_cnt5", 32'(f_cnt), 32'd5);
        f_wr = 1'b1;
        f_wd = 8'd99;
        f_rd = 1'b1;
        tick();
        f_wr = 1'b0;
        f_rd = 1'b0;
        check_value("f_simul_cnt", 32'(f_cnt), 32'd5);
        check_value("f_simul_rd", 32'({f_rvalid, f_rdata}), 32'({1'b1, 8'd10}));

        // Standalone FIFO: write at full is dropped
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            f_wr = 1'b1;
            f_wd = 8'(i);
            tick();
        end
        check_value("f_full", 32'({f_full, f_cnt}), 32'({1'b1, 9'd256}));
        f_wd = 8'hAA;
        tick();
        f_wr = 1'b0;
        check_value("f_full_wr_cnt", 32'(f_cnt), 32'd256);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check_value("f_full_intact", 32'({f_rvalid, f_rdata}), 32'({1'b1, 8'd0}));

        // Standalone FIFO: read at empty is dropped
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check_value("f_empty_rd_valid", 32'(f_rvalid), 32'd0);
        check_value("f_empty_cnt", 32'({f_empty, f_cnt}), 32'({1'b1, 9'd0}));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
